framed_shift_register: RTL

Parametrised successor to the lab shift register: a WIDTH-bit serial/parallel shift register with runtime bit order (MSB-first or LSB-first), separate sample and launch strobes for SPI mode-0 style timing, a bit counter with a word-complete pulse, and a captured-word output register. It sits between the SPI edge-detect/synchroniser logic and the memory FSM. Incoming serial bits are assembled into words without the FSM counting edges. Outgoing bits are launched on the falling peripheral edge.

---
 rtl/framed_shift_register.sv | 65 ++++++
 1 files changed

// File: rtl/framed_shift_register.sv
// framed_shift_register: serial/parallel shift register with runtime bit order,
// separate sample (rising SCLK) and launch (falling SCLK) strobes, a bit counter
// with a word-complete pulse, and a captured-word register.
//   clk, reset            : system clock, async active-high reset
//   peripheralClkEdge     : sample serialDataIn and shift
//   peripheralClkFall     : launch the outgoing bit into serialDataOut
//   lsbFirst              : 0 = MSB-first, 1 = LSB-first
//   parallelLoad/DataIn   : load the register (beats a shift)
//   serialDataIn          : incoming bit
//   parallelDataOut       : live register contents
//   serialDataOut         : registered outgoing bit
//   bitCount, wordDone    : bits into current word, one-clk completion pulse
//   rxWord                : last completed word
module framed_shift_register #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             peripheralClkEdge,
   input  logic             peripheralClkFall,
   input  logic             lsbFirst,
   input  logic             parallelLoad,
   input  logic [WIDTH-1:0] parallelDataIn,
   input  logic             serialDataIn,
   output logic [WIDTH-1:0] parallelDataOut,
   output logic             serialDataOut,
   output logic [CW-1:0]    bitCount,
   output logic             wordDone,
   output logic [WIDTH-1:0] rxWord
);
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] shifted;
   logic             last;
   assign parallelDataOut = sr;
   assign shifted = lsbFirst ? {serialDataIn, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], serialDataIn};
   assign last    = bitCount == CW'(WIDTH - 1);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sr            <= '0;
         serialDataOut <= 1'b0;
         bitCount      <= '0;
         wordDone      <= 1'b0;
         rxWord        <= '0;
      end else begin
         wordDone <= 1'b0;
         if (parallelLoad) begin
            sr            <= parallelDataIn;
            bitCount      <= '0;
            serialDataOut <= lsbFirst ? parallelDataIn[0] : parallelDataIn[WIDTH-1];
         end else begin
            if (peripheralClkEdge) begin
               sr       <= shifted;
               bitCount <= last ? '0 : bitCount + CW'(1);
               if (last) begin
                  rxWord   <= shifted;
                  wordDone <= 1'b1;
               end
            end
            // launch reads the pre-shift register even when a shift coincides
            if (peripheralClkFall)
               serialDataOut <= lsbFirst ? sr[0] : sr[WIDTH-1];
         end
      end
endmodule
